// File: rtl/vadd_engine.sv
// ---------------------------------------------------------------------------
// vadd_engine
//   Vector-add compute engine sitting behind the host CSR block. On a rising
//   edge of `launch` it computes c[i] = a[i] + b[i] for i = 0..length-1, one
//   64-bit element per memory beat. Each element is processed with three
//   single-beat requests (read a, read b, write c) over the shared memory
//   port. When the vector is done it pulses `finish` together with
//   `event_counter_valid` and reports the number of busy cycles.
//
// Ports
//   clock, reset          : rising-edge clock, asynchronous active-low reset
//   launch                : CSR level; a 0->1 edge while idle starts a run
//   finish                : one-cycle completion pulse
//   event_counter_valid   : one-cycle pulse, coincident with finish
//   event_counter_value   : busy-cycle count of the last run (held until next start)
//   length                : element count (0 is legal and completes at once)
//   a_addr/b_addr/c_addr  : element-aligned base byte addresses
//   mem_req_*             : request channel (accepted the cycle it is valid)
//   mem_wr_valid/bits     : write-data channel (accepted the cycle it is valid)
//   mem_rd_valid/bits     : read-data channel from memory
//   mem_rd_ready          : high only while the engine waits for read data
// ---------------------------------------------------------------------------
module vadd_engine #(
  parameter int HOST_DATA_BITS = 32,
  parameter int MEM_LEN_BITS   = 8,
  parameter int MEM_ADDR_BITS  = 64,
  parameter int MEM_DATA_BITS  = 64
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      launch,
  output logic                      finish,
  output logic                      event_counter_valid,
  output logic [HOST_DATA_BITS-1:0] event_counter_value,
  input  logic [HOST_DATA_BITS-1:0] length,
  input  logic [HOST_DATA_BITS-1:0] a_addr,
  input  logic [HOST_DATA_BITS-1:0] b_addr,
  input  logic [HOST_DATA_BITS-1:0] c_addr,
  output logic                      mem_req_valid,
  output logic                      mem_req_opcode,
  output logic [MEM_LEN_BITS-1:0]   mem_req_len,
  output logic [MEM_ADDR_BITS-1:0]  mem_req_addr,
  output logic                      mem_wr_valid,
  output logic [MEM_DATA_BITS-1:0]  mem_wr_bits,
  input  logic                      mem_rd_valid,
  input  logic [MEM_DATA_BITS-1:0]  mem_rd_bits,
  output logic                      mem_rd_ready
);

  // log2 of the element stride in bytes (8 bytes for 64-bit elements)
  localparam int STRIDE_SH = $clog2(MEM_DATA_BITS / 8);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RA_REQ = 3'd1,
    S_RA_DAT = 3'd2,
    S_RB_REQ = 3'd3,
    S_RB_DAT = 3'd4,
    S_WR_REQ = 3'd5,
    S_WR_DAT = 3'd6,
    S_DONE   = 3'd7
  } state_t;

  state_t                    state_q, state_d;
  logic                      launch_q, launch_d;
  logic [HOST_DATA_BITS-1:0] idx_q, idx_d;
  logic [HOST_DATA_BITS-1:0] counter_q, counter_d;
  logic [MEM_DATA_BITS-1:0]  a_q, a_d;
  logic [MEM_DATA_BITS-1:0]  b_q, b_d;

  logic start;
  logic last_elem;
  logic busy;

  // Saturating increment: the busy counter sticks at all-ones instead of wrapping.
  function automatic logic [HOST_DATA_BITS-1:0] sat_inc(input logic [HOST_DATA_BITS-1:0] v);
    if (v == {HOST_DATA_BITS{1'b1}}) begin
      return v;
    end
    return v + HOST_DATA_BITS'(1);
  endfunction

  // Element byte address: base is zero-extended, then base + idx*stride,
  // all wrapping modulo 2^MEM_ADDR_BITS.
  function automatic logic [MEM_ADDR_BITS-1:0] elem_addr(input logic [HOST_DATA_BITS-1:0] base,
                                                         input logic [HOST_DATA_BITS-1:0] idx);
    return MEM_ADDR_BITS'(base) + (MEM_ADDR_BITS'(idx) << STRIDE_SH);
  endfunction

  // Only a fresh 0->1 launch edge seen while idle starts a run.
  assign start     = (state_q == S_IDLE) && launch && !launch_q;
  assign last_elem = (idx_q == (length - HOST_DATA_BITS'(1)));
  assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (length == '0) ? S_DONE : S_RA_REQ;
        end
      end
      S_RA_REQ: state_d = S_RA_DAT;
      S_RA_DAT: if (mem_rd_valid) state_d = S_RB_REQ;
      S_RB_REQ: state_d = S_RB_DAT;
      S_RB_DAT: if (mem_rd_valid) state_d = S_WR_REQ;
      S_WR_REQ: state_d = S_WR_DAT;
      S_WR_DAT: state_d = last_elem ? S_DONE : S_RA_REQ;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output logic (Moore): everything is derived from the current state, so
  // an asynchronous reset forces every output to zero immediately.
  always_comb begin
    finish              = 1'b0;
    event_counter_valid = 1'b0;
    mem_req_valid       = 1'b0;
    mem_req_opcode      = 1'b0;
    mem_req_addr        = '0;
    mem_wr_valid        = 1'b0;
    mem_wr_bits         = '0;
    mem_rd_ready        = 1'b0;
    case (state_q)
      S_RA_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = elem_addr(a_addr, idx_q);
      end
      S_RA_DAT: mem_rd_ready = 1'b1;
      S_RB_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = elem_addr(b_addr, idx_q);
      end
      S_RB_DAT: mem_rd_ready = 1'b1;
      S_WR_REQ: begin
        mem_req_valid  = 1'b1;
        mem_req_opcode = 1'b1;
        mem_req_addr   = elem_addr(c_addr, idx_q);
      end
      S_WR_DAT: begin
        mem_wr_valid = 1'b1;
        mem_wr_bits  = a_q + b_q;  // carry out of the top bit is dropped
      end
      S_DONE: begin
        finish              = 1'b1;
        event_counter_valid = 1'b1;
      end
      default: ;
    endcase
  end

  assign mem_req_len         = '0;
  assign event_counter_value = counter_q;

  // Datapath next-state: element index, busy counter, operand holding regs
  always_comb begin
    launch_d  = launch;
    idx_d     = idx_q;
    counter_d = counter_q;
    a_d       = a_q;
    b_d       = b_q;
    if (start) begin
      idx_d     = '0;
      counter_d = '0;
    end else if (busy) begin
      counter_d = sat_inc(counter_q);
    end
    if ((state_q == S_RA_DAT) && mem_rd_valid) begin
      a_d = mem_rd_bits;
    end
    if ((state_q == S_RB_DAT) && mem_rd_valid) begin
      b_d = mem_rd_bits;
    end
    if ((state_q == S_WR_DAT) && !last_elem) begin
      idx_d = idx_q + HOST_DATA_BITS'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      launch_q  <= 1'b0;
      idx_q     <= '0;
      counter_q <= '0;
      a_q       <= '0;
      b_q       <= '0;
    end else begin
      launch_q  <= launch_d;
      idx_q     <= idx_d;
      counter_q <= counter_d;
      a_q       <= a_d;
      b_q       <= b_d;
    end
  end

endmodule

// File: tb/tb_vadd_engine.sv
// ---------------------------------------------------------------------------
// tb_vadd_engine
//   Directed bench for vadd_engine. A behavioural memory with configurable
//   read latency serves the 64-bit-address instance; a second instance built
//   with 32-bit memory addresses checks address wrap-around.
// ---------------------------------------------------------------------------
module tb_vadd_engine;

  logic        clock;
  logic        reset;
  logic        launch;
  logic        finish;
  logic        event_counter_valid;
  logic [31:0] event_counter_value;
  logic [31:0] length, a_addr, b_addr, c_addr;
  logic        mem_req_valid, mem_req_opcode;
  logic [7:0]  mem_req_len;
  logic [63:0] mem_req_addr;
  logic        mem_wr_valid;
  logic [63:0] mem_wr_bits;
  logic        mem_rd_valid;
  logic [63:0] mem_rd_bits;
  logic        mem_rd_ready;

  // 32-bit-address instance
  logic        launch32;
  logic        finish32, evv32;
  logic [31:0] ev32_value;
  logic [31:0] length32, a32, b32, c32;
  logic        req_valid32, req_opcode32;
  logic [7:0]  req_len32;
  logic [31:0] req_addr32;
  logic        wr_valid32;
  logic [63:0] wr_bits32;
  logic        rd_valid32;
  logic [63:0] rd_bits32;
  logic        rd_ready32;

  vadd_engine #(.HOST_DATA_BITS(32), .MEM_LEN_BITS(8), .MEM_ADDR_BITS(64), .MEM_DATA_BITS(64)) u_dut (
    .clock(clock), .reset(reset), .launch(launch), .finish(finish),
    .event_counter_valid(event_counter_valid), .event_counter_value(event_counter_value),
    .length(length), .a_addr(a_addr), .b_addr(b_addr), .c_addr(c_addr),
    .mem_req_valid(mem_req_valid), .mem_req_opcode(mem_req_opcode), .mem_req_len(mem_req_len),
    .mem_req_addr(mem_req_addr), .mem_wr_valid(mem_wr_valid), .mem_wr_bits(mem_wr_bits),
    .mem_rd_valid(mem_rd_valid), .mem_rd_bits(mem_rd_bits), .mem_rd_ready(mem_rd_ready)
  );

  vadd_engine #(.HOST_DATA_BITS(32), .MEM_LEN_BITS(8), .MEM_ADDR_BITS(32), .MEM_DATA_BITS(64)) u_dut32 (
    .clock(clock), .reset(reset), .launch(launch32), .finish(finish32),
    .event_counter_valid(evv32), .event_counter_value(ev32_value),
    .length(length32), .a_addr(a32), .b_addr(b32), .c_addr(c32),
    .mem_req_valid(req_valid32), .mem_req_opcode(req_opcode32), .mem_req_len(req_len32),
    .mem_req_addr(req_addr32), .mem_wr_valid(wr_valid32), .mem_wr_bits(wr_bits32),
    .mem_rd_valid(rd_valid32), .mem_rd_bits(rd_bits32), .mem_rd_ready(rd_ready32)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- memory model and monitors (all at negedge) -------------
  logic [63:0] mem [logic [63:0]];
  int          lat_cfg = 1;
  int          stray_cfg = 0;
  bit          rd_pend = 0;
  int          rd_wait = 0;
  int          stray_left = 0;
  logic [63:0] rd_data = '0;
  logic [63:0] wr_addr = '0;
  int          rd_consumed = 0;
  int          req_total = 0;
  int          fin_cnt = 0;
  logic [31:0] ev_at_fin = '0;
  int          evv_bad = 0;
  int          len_bad = 0;
  int          fin32_cnt = 0;
  logic [31:0] ev32_at_fin = '0;
  logic [31:0] rdq32 [$];

  function automatic logic [63:0] mem_rd(input logic [63:0] a);
    if (mem.exists(a)) return mem[a];
    return 64'd0;
  endfunction

  initial begin
    mem_rd_valid = 1'b0;
    mem_rd_bits  = '0;
    forever begin
      @(negedge clock);
      if (finish) begin
        fin_cnt++;
        ev_at_fin = event_counter_value;
      end
      if (event_counter_valid !== finish) evv_bad++;
      if (mem_req_valid && (mem_req_len != 8'd0)) len_bad++;
      if (finish32) begin
        fin32_cnt++;
        ev32_at_fin = ev32_value;
      end
      if (req_valid32 && !req_opcode32) rdq32.push_back(req_addr32);
      if (!reset) begin
        rd_pend      = 0;
        stray_left   = 0;
        mem_rd_valid = 1'b0;
      end else begin
        if (mem_req_valid) req_total++;
        if (mem_rd_valid) begin
          if (stray_left != 0) begin
            stray_left--;
            if (mem_rd_ready) rd_consumed++;
          end else begin
            mem_rd_valid = 1'b0;
          end
        end
        if (mem_req_valid && !mem_req_opcode) begin
          rd_pend = 1;
          rd_wait = lat_cfg;
          rd_data = mem_rd(mem_req_addr);
        end else if (rd_pend) begin
          rd_wait--;
          if (rd_wait == 0) begin
            rd_pend      = 0;
            mem_rd_valid = 1'b1;
            mem_rd_bits  = rd_data;
            stray_left   = stray_cfg;
            if (mem_rd_ready) rd_consumed++;
          end
        end
        if (mem_req_valid && mem_req_opcode) wr_addr = mem_req_addr;
        if (mem_wr_valid) mem[wr_addr] = mem_wr_bits;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      #2;
    end
  endtask

  task automatic load_t1();
    for (int i = 0; i < 4; i++) begin
      mem[64'h100 + 64'(i * 8)] = 64'(i + 1);
      mem[64'h200 + 64'(i * 8)] = 64'((i + 1) * 10);
      mem[64'h300 + 64'(i * 8)] = 64'd0;
    end
    a_addr = 32'h100;
    b_addr = 32'h200;
    c_addr = 32'h300;
  endtask

  task automatic check_t1(input string tag);
    chk({tag, "_c0"}, mem_rd(64'h300), 64'd11);
    chk({tag, "_c1"}, mem_rd(64'h308), 64'd22);
    chk({tag, "_c2"}, mem_rd(64'h310), 64'd33);
    chk({tag, "_c3"}, mem_rd(64'h318), 64'd44);
    chk({tag, "_count"}, 64'(ev_at_fin), 64'd24);
  endtask

  // Launch a run and wait (bounded) for finish; launch stays high if keep.
  task automatic run_vec(input string tag, input logic [31:0] len, input int lat,
                         input int stray, input bit keep);
    int f0;
    int n;
    lat_cfg   = lat;
    stray_cfg = stray;
    length    = len;
    f0        = fin_cnt;
    launch    = 1'b1;
    n         = 0;
    while ((fin_cnt == f0) && (n < 400)) begin
      step(1);
      n++;
    end
    if (!keep) launch = 1'b0;
    step(2);
    chk({tag, "_finish_once"}, 64'(fin_cnt - f0), 64'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int f0;
    int r0;
    int n;
    bit found;
    reset    = 1'b1;
    launch   = 1'b0;
    length   = '0;
    a_addr   = '0;
    b_addr   = '0;
    c_addr   = '0;
    launch32 = 1'b0;
    length32 = 32'd2;
    a32      = 32'hFFFF_FFF8;
    b32      = 32'h0000_1000;
    c32      = 32'h0000_2000;
    rd_valid32 = 1'b1;
    rd_bits32  = 64'd5;
    #1 reset = 1'b0;
    step(3);

    // Reset state
    chk("rst_finish", {63'd0, finish}, 64'd0);
    chk("rst_evv", {63'd0, event_counter_valid}, 64'd0);
    chk("rst_req_valid", {63'd0, mem_req_valid}, 64'd0);
    chk("rst_rd_ready", {63'd0, mem_rd_ready}, 64'd0);
    chk("rst_count", 64'(event_counter_value), 64'd0);
    reset = 1'b1;
    step(2);

    // T1: basic 4-element vector, 1-cycle read latency
    load_t1();
    r0 = rd_consumed;
    run_vec("t1", 32'd4, 1, 0, 1'b0);
    check_t1("t1");
    chk("t1_rd_beats", 64'(rd_consumed - r0), 64'd8);
    step(3);
    chk("t1_count_hold", 64'(event_counter_value), 64'd24);

    // T2: zero length completes the cycle after the launch edge
    r0       = req_total;
    length   = 32'd0;
    launch   = 1'b1;
    step(1);
    chk("t2_finish", {63'd0, finish}, 64'd1);
    chk("t2_evv", {63'd0, event_counter_valid}, 64'd1);
    chk("t2_count", 64'(event_counter_value), 64'd0);
    step(1);
    chk("t2_finish_drop", {63'd0, finish}, 64'd0);
    launch = 1'b0;
    step(2);
    chk("t2_no_req", 64'(req_total - r0), 64'd0);

    // T3: carry dropped, 5-cycle read latency with a lingering stray beat
    mem[64'h400] = 64'hFFFF_FFFF_FFFF_FFFF;
    mem[64'h500] = 64'd2;
    mem[64'h600] = 64'hDEAD;
    a_addr = 32'h400;
    b_addr = 32'h500;
    c_addr = 32'h600;
    r0 = rd_consumed;
    run_vec("t3", 32'd1, 5, 1, 1'b0);
    chk("t3_c", mem_rd(64'h600), 64'd1);
    chk("t3_count", 64'(ev_at_fin), 64'd14);
    chk("t3_rd_beats", 64'(rd_consumed - r0), 64'd2);

    // T4: launch held high after finish must not restart
    load_t1();
    run_vec("t4a", 32'd4, 1, 0, 1'b1);
    f0 = fin_cnt;
    r0 = req_total;
    step(10);
    chk("t4_no_rerun_fin", 64'(fin_cnt - f0), 64'd0);
    chk("t4_no_rerun_req", 64'(req_total - r0), 64'd0);
    launch = 1'b0;
    step(1);
    load_t1();
    run_vec("t4b", 32'd4, 1, 0, 1'b0);
    check_t1("t4b");

    // T5: asynchronous reset during WR_REQ of element 2
    load_t1();
    lat_cfg   = 1;
    stray_cfg = 0;
    length    = 32'd4;
    f0        = fin_cnt;
    launch    = 1'b1;
    found     = 0;
    n         = 0;
    while (!found && (n < 200)) begin
      step(1);
      n++;
      if (mem_req_valid && mem_req_opcode && (mem_req_addr == 64'h308)) found = 1;
    end
    chk("t5_reached_wr_req", {63'd0, found}, 64'd1);
    reset = 1'b0;
    #1;
    chk("t5_req_valid", {63'd0, mem_req_valid}, 64'd0);
    chk("t5_req_addr", mem_req_addr, 64'd0);
    chk("t5_count", 64'(event_counter_value), 64'd0);
    chk("t5_finish", {63'd0, finish}, 64'd0);
    launch = 1'b0;
    step(3);
    chk("t5_no_finish", 64'(fin_cnt - f0), 64'd0);
    reset = 1'b1;
    step(2);
    load_t1();
    run_vec("t5r", 32'd4, 1, 0, 1'b0);
    check_t1("t5r");

    // T6: 32-bit address build wraps the second a address to zero
    rdq32.delete();
    f0       = fin32_cnt;
    launch32 = 1'b1;
    n        = 0;
    while ((fin32_cnt == f0) && (n < 200)) begin
      step(1);
      n++;
    end
    launch32 = 1'b0;
    step(2);
    chk("t6_finish", 64'(fin32_cnt - f0), 64'd1);
    chk("t6_count", 64'(ev32_at_fin), 64'd12);
    chk("t6_nreads", 64'(rdq32.size()), 64'd4);
    if (rdq32.size() == 4) begin
      chk("t6_a0", 64'(rdq32[0]), 64'hFFFF_FFF8);
      chk("t6_a1_wrap", 64'(rdq32[2]), 64'h0);
      chk("t6_b1", 64'(rdq32[3]), 64'h1008);
    end

    chk("evv_with_finish", 64'(evv_bad), 64'd0);
    chk("req_len_zero", 64'(len_bad), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
